// File: rtl/vending_machine_unit.sv
`default_nettype none
// ============================================================================
// vending_machine_unit : four-item purchase controller with per-item stock
// Revision: 1.0
// ============================================================================
module vending_machine_unit #(
   parameter logic [3:0] PRICE0     = 4'd2,
   parameter logic [3:0] PRICE1     = 4'd3,
   parameter logic [3:0] PRICE2     = 4'd4,
   parameter logic [3:0] PRICE3     = 4'd6,
   parameter logic [3:0] INIT_STOCK = 4'd5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [1:0] tag,
   input  logic [2:0] count,
   input  logic [3:0] money,
   input  logic       restock,
   output logic       resp_valid,
   output logic       possibility,
   output logic [3:0] remaining_money,
   output logic [3:0] sold_out
);

   logic [3:0] r_stock [4];
   logic [3:0] w_price;
   logic [3:0] w_sel_stock;
   logic [6:0] w_cost;
   logic       w_accept;

   always_comb begin
      w_price = PRICE0;
      case (tag)
         2'd1:    w_price = PRICE1;
         2'd2:    w_price = PRICE2;
         2'd3:    w_price = PRICE3;
         default: w_price = PRICE0;
      endcase
   end

   assign w_sel_stock = r_stock[tag];

   // Full 7-bit product so an expensive order is never aliased below money
   assign w_cost = {3'b000, w_price} * {4'b0000, count};

   assign w_accept = req_valid && !restock && (count != 3'd0) &&
                     (w_sel_stock >= {1'b0, count}) &&
                     ({3'b000, money} >= w_cost);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid      <= 1'b0;
         possibility     <= 1'b0;
         remaining_money <= 4'd0;
         for (int i = 0; i < 4; i++) begin
            r_stock[i] <= INIT_STOCK;
         end
      end else begin
         resp_valid <= req_valid;
         if (req_valid) begin
            possibility     <= w_accept;
            remaining_money <= w_accept ? (money - w_cost[3:0]) : money;
         end
         // Restock wins over any concurrent purchase
         if (restock) begin
            for (int i = 0; i < 4; i++) begin
               r_stock[i] <= INIT_STOCK;
            end
         end else if (w_accept) begin
            r_stock[tag] <= w_sel_stock - {1'b0, count};
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sold_out
         assign sold_out[gi] = (r_stock[gi] == 4'd0);
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_unit.sv
`default_nettype none
// ============================================================================
// tb_vending_machine_unit : directed and randomized checks against a price/stock model
// Revision: 1.0
// ============================================================================
module tb_vending_machine_unit;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic [1:0] tag;
   logic [2:0] count;
   logic [3:0] money;
   logic       restock;
   logic       resp_valid;
   logic       possibility;
   logic [3:0] remaining_money;
   logic [3:0] sold_out;

   int checks   = 0;
   int failures = 0;

   int price [4] = '{2, 3, 4, 6};
   int m_stock [4];
   bit e_rv;
   bit e_poss;
   int e_rem;

   vending_machine_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .tag             (tag),
      .count           (count),
      .money           (money),
      .restock         (restock),
      .resp_valid      (resp_valid),
      .possibility     (possibility),
      .remaining_money (remaining_money),
      .sold_out        (sold_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] exp_sold();
      logic [3:0] s;
      for (int i = 0; i < 4; i++) s[i] = (m_stock[i] == 0);
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_stock[i] = 5;
      e_rv = 0; e_poss = 0; e_rem = 0;
   endtask

   // Drive one cycle of inputs, advance the model, and settle past the edge
   task automatic do_cycle(input bit v, input int t, input int c, input int m, input bit rs);
      int  cost;
      bit  ok;
      @(negedge clk);
      req_valid = v; tag = 2'(t); count = 3'(c); money = 4'(m); restock = rs;
      @(posedge clk);
      cost = price[t] * c;
      ok   = v && !rs && (c > 0) && (m_stock[t] >= c) && (m >= cost);
      e_rv = v;
      if (v) begin
         e_poss = ok;
         e_rem  = ok ? (m - cost) : m;
      end
      if (rs) begin
         for (int i = 0; i < 4; i++) m_stock[i] = 5;
      end else if (ok) begin
         m_stock[t] = m_stock[t] - c;
      end
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 0; tag = 0; count = 0; money = 0; restock = 0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++;
      if ({resp_valid, possibility, remaining_money, sold_out} !== 10'b0) begin
         failures++;
         $display("FAIL reset_state: got rv=%0b poss=%0b rem=%0d so=%b, want all 0",
                  resp_valid, possibility, remaining_money, sold_out);
      end
   endtask

   task automatic test_plan();
      // 1..4: single purchases and price/stock rejects
      int t_tab [4] = '{3, 2, 0, 0};
      int c_tab [4] = '{1, 1, 2, 3};
      int p_tab [4] = '{0, 1, 1, 0};
      int r_tab [4] = '{5, 1, 1, 5};
      for (int k = 0; k < 4; k++) begin
         do_cycle(1, t_tab[k], c_tab[k], 5, 0);
         checks++;
         if (resp_valid !== 1'b1 || possibility !== p_tab[k][0] ||
             remaining_money !== 4'(r_tab[k]) || sold_out !== 4'b0000) begin
            failures++;
            $display("FAIL plan_step%0d: got rv=%0b poss=%0b rem=%0d so=%b, want rv=1 poss=%0d rem=%0d so=0000",
                     k + 1, resp_valid, possibility, remaining_money, sold_out, p_tab[k], r_tab[k]);
         end
      end
      // 5: drain item 1
      do_cycle(1, 1, 3, 15, 0);
      checks++;
      if (possibility !== 1'b1 || remaining_money !== 4'd6) begin
         failures++;
         $display("FAIL drain_a: got poss=%0b rem=%0d, want poss=1 rem=6", possibility, remaining_money);
      end
      do_cycle(1, 1, 2, 15, 0);
      checks++;
      if (possibility !== 1'b1 || remaining_money !== 4'd9 || sold_out !== 4'b0010) begin
         failures++;
         $display("FAIL drain_b: got poss=%0b rem=%0d so=%b, want poss=1 rem=9 so=0010",
                  possibility, remaining_money, sold_out);
      end
      do_cycle(1, 1, 1, 15, 0);
      checks++;
      if (resp_valid !== 1'b1 || possibility !== 1'b0 || remaining_money !== 4'd15 || sold_out !== 4'b0010) begin
         failures++;
         $display("FAIL drain_empty: got rv=%0b poss=%0b rem=%0d so=%b, want rv=1 poss=0 rem=15 so=0010",
                  resp_valid, possibility, remaining_money, sold_out);
      end
      do_cycle(0, 0, 0, 0, 1);
      checks++;
      if (resp_valid !== 1'b0 || possibility !== 1'b0 || remaining_money !== 4'd15 || sold_out !== 4'b0000) begin
         failures++;
         $display("FAIL restock_hold: got rv=%0b poss=%0b rem=%0d so=%b, want rv=0 poss=0 rem=15 so=0000",
                  resp_valid, possibility, remaining_money, sold_out);
      end
      // 6: corners
      do_cycle(1, 2, 0, 9, 0);
      checks++;
      if (possibility !== 1'b0 || remaining_money !== 4'd9) begin
         failures++;
         $display("FAIL count_zero: got poss=%0b rem=%0d, want poss=0 rem=9", possibility, remaining_money);
      end
      do_cycle(1, 1, 5, 15, 0);
      checks++;
      if (possibility !== 1'b1 || remaining_money !== 4'd0 || sold_out !== 4'b0010) begin
         failures++;
         $display("FAIL exact_money: got poss=%0b rem=%0d so=%b, want poss=1 rem=0 so=0010",
                  possibility, remaining_money, sold_out);
      end
      do_cycle(1, 0, 1, 9, 1);
      checks++;
      if (resp_valid !== 1'b1 || possibility !== 1'b0 || remaining_money !== 4'd9 || sold_out !== 4'b0000) begin
         failures++;
         $display("FAIL restock_req: got rv=%0b poss=%0b rem=%0d so=%b, want rv=1 poss=0 rem=9 so=0000",
                  resp_valid, possibility, remaining_money, sold_out);
      end
      // Expensive order whose truncated cost would look affordable: 6*7=42
      do_cycle(1, 3, 7, 15, 0);
      checks++;
      if (possibility !== 1'b0 || remaining_money !== 4'd15) begin
         failures++;
         $display("FAIL wide_cost: got poss=%0b rem=%0d, want poss=0 rem=15", possibility, remaining_money);
      end
   endtask

   task automatic test_back_to_back();
      do_cycle(0, 0, 0, 0, 1);
      for (int k = 0; k < 6; k++) begin
         do_cycle(1, 0, 1, 15, 0);
         checks++;
         if (resp_valid !== 1'b1 || possibility !== (k < 5) ||
             remaining_money !== ((k < 5) ? 4'd13 : 4'd15) || sold_out[0] !== (k >= 4)) begin
            failures++;
            $display("FAIL b2b_%0d: got rv=%0b poss=%0b rem=%0d so0=%0b, want rv=1 poss=%0b rem=%0d so0=%0b",
                     k, resp_valid, possibility, remaining_money, sold_out[0],
                     (k < 5), (k < 5) ? 13 : 15, (k >= 4));
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         do_cycle(($urandom % 4) != 0, $urandom % 4, $urandom % 8, $urandom % 16,
                  ($urandom % 20) == 0);
         checks++;
         if (resp_valid !== e_rv || possibility !== e_poss ||
             remaining_money !== 4'(e_rem) || sold_out !== exp_sold()) begin
            failures++;
            $display("FAIL random_%0d: got rv=%0b poss=%0b rem=%0d so=%b, want rv=%0b poss=%0b rem=%0d so=%b",
                     n, resp_valid, possibility, remaining_money, sold_out,
                     e_rv, e_poss, e_rem, exp_sold());
         end
      end
   endtask

   task automatic test_async_reset();
      do_cycle(0, 0, 0, 0, 1);
      do_cycle(1, 2, 3, 15, 0);
      // Mid-cycle assertion, well clear of any clock edge
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({resp_valid, possibility, remaining_money, sold_out} !== 10'b0) begin
         failures++;
         $display("FAIL async_reset: got rv=%0b poss=%0b rem=%0d so=%b, want all 0",
                  resp_valid, possibility, remaining_money, sold_out);
      end
      @(negedge clk);
      req_valid = 0; restock = 0;
      rst_n = 1'b1;
      // Stock must be full again: item 2 accepts a count of 5 (cost 20 > 15 rejects, so use count 3)
      do_cycle(1, 2, 3, 15, 0);
      do_cycle(1, 2, 2, 15, 0);
      checks++;
      if (possibility !== 1'b1 || remaining_money !== 4'd7 || sold_out !== 4'b0100) begin
         failures++;
         $display("FAIL post_reset_stock: got poss=%0b rem=%0d so=%b, want poss=1 rem=7 so=0100",
                  possibility, remaining_money, sold_out);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 0; tag = 0; count = 0; money = 0; restock = 0;
      model_reset();
      test_reset();
      test_plan();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vending_machine_unit.md
Name: vending_machine_unit

Overview:
- Clocked purchase controller for a four-item vending machine.
- Each request selects one item (tag), a quantity (count) and the inserted money.
- The block checks price and stock, registers a go/no-go verdict plus change or refund, and decrements per-item stock on success.
- Sits between the coin/keypad front end and the dispense actuator.

Parameters:
PRICE0, 2, unit price of item 0 (4-bit, 0..15)
PRICE1, 3, unit price of item 1
PRICE2, 4, unit price of item 2
PRICE3, 6, unit price of item 3
INIT_STOCK, 5, per-item stock loaded at reset and on restock (4-bit, 0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  purchase request strobe, sampled on clk rising edge
tag  input  2  item select 0..3
count  input  3  requested quantity 0..7
money  input  4  inserted money 0..15
restock  input  1  reload all stock counters to INIT_STOCK
resp_valid  output  1  one-cycle pulse: possibility/remaining_money updated
possibility  output  1  1 = purchase accepted and dispensed
remaining_money  output  4  change on accept, full refund (money) on reject
sold_out  output  4  bit i = 1 when stock of item i is 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - all four stock counters = INIT_STOCK
  - resp_valid = 0, possibility = 0, remaining_money = 0
  - sold_out reflects INIT_STOCK: all 0 unless INIT_STOCK = 0
- Release of reset is synchronous to clk.
- Cost = PRICE[tag] * count, computed at 7 bits (max 105). No truncation before compare.
- Accept condition, all must hold: req_valid = 1, restock = 0, count != 0, stock[tag] >= count, money >= cost.
- Latency: results appear on the clock edge that samples req_valid (registered, 1-cycle latency from input setup). resp_valid is high for exactly that one cycle.
- Accept: possibility = 1, remaining_money = money - cost (fits 4 bits), stock[tag] -= count.
- Reject: possibility = 0, remaining_money = money. Stock is unchanged.
- Reject cases:
  - count = 0
  - insufficient stock
  - insufficient money
  - restock asserted in the same cycle
- Between requests, possibility and remaining_money hold their last values. resp_valid = 0.
- Back-to-back requests on consecutive cycles are each evaluated against stock already updated by the previous request. There are no bubbles.
- Restock: on a clk edge with restock = 1, all counters are set to INIT_STOCK. Restock has priority over a simultaneous request, which is rejected with full refund; resp_valid still pulses.
- Stock never underflows; the accept condition guarantees it.
- sold_out is combinational from the stock registers.
- No internal state machine beyond the stock registers and output registers. The block is fully pipelined at one request per cycle.
- Exact equality (money == cost) is accepted with remaining_money = 0.

Test Plan:
1. Reset, then req tag=3 count=1 money=5 -> resp_valid pulse, possibility=0, remaining_money=5 (price 6 > 5); stock3 stays 5.
2. req tag=2 count=1 money=5 -> possibility=1, remaining_money=1; stock2 = 4.
3. req tag=0 count=2 money=5 -> possibility=1, remaining_money=1; stock0 = 3.
4. req tag=0 count=3 money=5 -> possibility=0, remaining_money=5 (cost 6); stock0 stays 3.
5. Drain item 1 with money=15: count=3 (change 6), count=2 (change 9), then count=1 -> reject, refund 15, sold_out[1]=1. Then assert restock -> sold_out[1]=0, stock1 = 5.
6. Corner checks:
   - count=0 money=9 -> reject, refund 9.
   - tag=1 count=5 money=15 -> accept, change 0.
   - restock together with a valid request -> reject, refund, stock = INIT_STOCK.
   - rst_n asserted mid-sequence -> outputs 0 immediately, without waiting for a clock edge.
